// File: rtl/io_responder.sv
// CPU IO-bus peripheral endpoint: LED register, buffered input port with
// full/overrun status, handshaked display output port and a cycle counter.
module io_responder #(
  parameter int LED_W = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       io_addr,
  input  logic [31:0]      io_dout,
  input  logic             io_we,
  input  logic             io_rd,
  output logic [31:0]      io_din,
  output logic [LED_W-1:0] led,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  output logic [31:0]      out_data,
  input  logic             out_ack
);

  localparam logic [7:0] A_LED      = 8'h00;
  localparam logic [7:0] A_IN_STAT  = 8'h04;
  localparam logic [7:0] A_IN_DATA  = 8'h08;
  localparam logic [7:0] A_OUT_STAT = 8'h0C;
  localparam logic [7:0] A_OUT_DATA = 8'h10;
  localparam logic [7:0] A_CNT      = 8'h14;

  logic [LED_W-1:0] r_led;
  logic [31:0]      r_in_buf;
  logic             r_in_full;
  logic             r_in_ovr;
  logic             r_out_valid;
  logic [31:0]      r_out_data;
  logic             r_out_err;
  logic [CNT_W-1:0] r_cnt;

  logic w_wr_led, w_wr_out, w_wr_cnt;
  logic w_rd_istat, w_rd_idata, w_rd_ostat;
  logic w_in_take, w_ovr_set, w_err_set;

  assign w_wr_led   = io_we && (io_addr == A_LED);
  assign w_wr_out   = io_we && (io_addr == A_OUT_DATA);
  assign w_wr_cnt   = io_we && (io_addr == A_CNT);
  assign w_rd_istat = io_rd && (io_addr == A_IN_STAT);
  assign w_rd_idata = io_rd && (io_addr == A_IN_DATA);
  assign w_rd_ostat = io_rd && (io_addr == A_OUT_STAT);

  // A read of IN_DATA frees the buffer in the same edge, so a coincident
  // new word is latched rather than counted as an overrun.
  assign w_in_take = in_valid && (!r_in_full || w_rd_idata);
  assign w_ovr_set = in_valid && r_in_full && !w_rd_idata;
  // Busy is judged on the registered out_valid, so a write racing a
  // completing handshake is still rejected.
  assign w_err_set = w_wr_out && r_out_valid;

  always_comb begin
    io_din = 32'h0;
    case (io_addr)
      A_LED:      io_din = 32'(r_led);
      A_IN_STAT:  io_din = {30'h0, r_in_ovr, r_in_full};
      A_IN_DATA:  io_din = r_in_buf;
      A_OUT_STAT: io_din = {30'h0, r_out_err, ~r_out_valid};
      A_OUT_DATA: io_din = r_out_data;
      A_CNT:      io_din = 32'(r_cnt);
      default:    io_din = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_led       <= '0;
      r_in_buf    <= '0;
      r_in_full   <= 1'b0;
      r_in_ovr    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_wr_led) r_led <= io_dout[LED_W-1:0];

      if (w_in_take) begin
        r_in_buf  <= in_data;
        r_in_full <= 1'b1;
      end else if (w_rd_idata) begin
        r_in_full <= 1'b0;
      end
      r_in_ovr <= w_ovr_set || (r_in_ovr && !w_rd_istat);

      if (w_wr_out && !r_out_valid) r_out_data <= io_dout;
      r_out_valid <= (r_out_valid && !out_ack) || (w_wr_out && !r_out_valid);
      r_out_err   <= w_err_set || (r_out_err && !w_rd_ostat);

      r_cnt <= w_wr_cnt ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign led       = r_led;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder: stimulus pushes expected values into a
// scoreboard queue, a negedge monitor pops and compares.
module tb_io_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  io_addr;
  logic [31:0] io_dout;
  logic        io_we, io_rd;
  logic [31:0] io_din;
  logic [15:0] led;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ack;

  logic [31:0] c4_din;
  logic [15:0] c4_led;
  logic        c4_ov;
  logic [31:0] c4_od;

  always #5 clk = ~clk;

  io_responder #(.LED_W(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .io_addr(io_addr), .io_dout(io_dout),
    .io_we(io_we), .io_rd(io_rd), .io_din(io_din), .led(led),
    .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid),
    .out_data(out_data), .out_ack(out_ack)
  );

  // Narrow-counter instance used only for the wrap check.
  io_responder #(.LED_W(16), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .io_addr(8'h14), .io_dout(32'h0),
    .io_we(1'b0), .io_rd(1'b0), .io_din(c4_din), .led(c4_led),
    .in_valid(1'b0), .in_data(32'h0), .out_valid(c4_ov),
    .out_data(c4_od), .out_ack(1'b0)
  );

  typedef struct {
    string       nm;
    int          sel;   // 0 io_din, 1 led, 2 out_valid, 3 out_data, 4 dut4 io_din
    logic [31:0] exp;
  } item_t;

  item_t sb[$];
  int    n_cmp = 0;
  int    n_err = 0;
  logic  chk = 1'b0;

  function automatic logic [31:0] pick(int sel);
    case (sel)
      0:       return io_din;
      1:       return 32'(led);
      2:       return 32'(out_valid);
      3:       return out_data;
      default: return c4_din;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk) begin
      item_t it;
      logic [31:0] act;
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_underflow: monitor saw a check with no expectation queued");
      end else begin
        it  = sb.pop_front();
        act = pick(it.sel);
        if (act !== it.exp) begin
          n_err++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", it.nm, act, it.exp);
        end
      end
    end
  end

  // One check occupies exactly one clock cycle.
  task automatic check(string nm, int sel, logic [7:0] a, logic [31:0] e, logic rd = 1'b0);
    item_t it;
    it.nm = nm; it.sel = sel; it.exp = e;
    io_addr = a;
    io_rd   = rd;
    sb.push_back(it);
    chk = 1'b1;
    @(posedge clk); #1;
    chk   = 1'b0;
    io_rd = 1'b0;
  endtask

  task automatic wr(logic [7:0] a, logic [31:0] d);
    io_addr = a; io_dout = d; io_we = 1'b1;
    @(posedge clk); #1;
    io_we = 1'b0;
  endtask

  task automatic pulse_in(logic [31:0] d);
    in_valid = 1'b1; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; io_addr = 8'h0; io_dout = 32'h0; io_we = 1'b0; io_rd = 1'b0;
    in_valid = 1'b0; in_data = 32'h0; out_ack = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // counter starts at 0 in the first post-reset cycle
    check("cnt_after_rst_0", 0, 8'h14, 32'd0);
    check("cnt_after_rst_1", 0, 8'h14, 32'd1);
    check("cnt_after_rst_2", 0, 8'h14, 32'd2);
    check("rst_led_reg",   0, 8'h00, 32'h0);
    check("rst_in_stat",   0, 8'h04, 32'h0);
    check("rst_out_stat",  0, 8'h0C, 32'h1);
    check("rst_led_port",  1, 8'h00, 32'h0);
    check("rst_out_valid", 2, 8'h00, 32'h0);

    // LED
    wr(8'h00, 32'hFFFF_A5A5);
    check("led_port",     1, 8'h00, 32'h0000_A5A5);
    check("led_readback", 0, 8'h00, 32'h0000_A5A5);
    wr(8'h03, 32'h0000_1111);
    check("led_unaligned_wr", 1, 8'h00, 32'h0000_A5A5);
    check("unaligned_rd",     0, 8'h01, 32'h0);
    check("unmapped_rd",      0, 8'h18, 32'h0);

    // input buffer
    pulse_in(32'h1234);
    check("in_stat_full",  0, 8'h04, 32'h1);
    check("in_data_1",     0, 8'h08, 32'h1234);
    pulse_in(32'h5678);
    check("in_stat_ovr",   0, 8'h04, 32'h3);
    check("in_data_kept",  0, 8'h08, 32'h1234);
    check("in_data_rd",    0, 8'h08, 32'h1234, 1'b1);
    check("in_stat_after_rd", 0, 8'h04, 32'h2);
    check("in_stat_rd",    0, 8'h04, 32'h2, 1'b1);
    check("in_stat_clr",   0, 8'h04, 32'h0);
    pulse_in(32'h1);
    in_valid = 1'b1; in_data = 32'h9;
    check("in_rd_concurrent", 0, 8'h08, 32'h1, 1'b1);
    in_valid = 1'b0;
    check("in_data_new",   0, 8'h08, 32'h9);
    check("in_stat_no_ovr",0, 8'h04, 32'h1);

    // output handshake
    wr(8'h10, 32'hDEAD);
    check("out_valid_set", 2, 8'h00, 32'h1);
    check("out_data_set",  3, 8'h00, 32'hDEAD);
    check("out_stat_busy", 0, 8'h0C, 32'h0);
    wr(8'h10, 32'hBEEF);
    check("out_data_held", 3, 8'h00, 32'hDEAD);
    check("out_stat_err",  0, 8'h0C, 32'h2);
    out_ack = 1'b1;
    @(posedge clk); #1;
    out_ack = 1'b0;
    check("out_valid_clr", 2, 8'h00, 32'h0);
    check("out_stat_ack",  0, 8'h0C, 32'h3);
    check("out_data_rd",   0, 8'h10, 32'hDEAD);
    check("out_stat_rd",   0, 8'h0C, 32'h3, 1'b1);
    check("out_stat_errclr", 0, 8'h0C, 32'h1);
    wr(8'h10, 32'h77);
    io_addr = 8'h10; io_dout = 32'h88; io_we = 1'b1; out_ack = 1'b1;
    @(posedge clk); #1;
    io_we = 1'b0; out_ack = 1'b0;
    check("race_valid",    2, 8'h00, 32'h0);
    check("race_data",     3, 8'h00, 32'h77);
    check("race_stat",     0, 8'h0C, 32'h3);

    // counter clear
    idle(10);
    wr(8'h14, 32'hFFFF_FFFF);
    check("cnt_clr_0", 0, 8'h14, 32'd0);
    check("cnt_clr_1", 0, 8'h14, 32'd1);

    // reset mid-operation, with a concurrent in_valid
    wr(8'h10, 32'h55);
    pulse_in(32'hA);
    pulse_in(32'hB);
    check("pre_rst_in_stat", 0, 8'h04, 32'h3);
    check("pre_rst_valid",   2, 8'h00, 32'h1);
    rst = 1'b1; in_valid = 1'b1; in_data = 32'hAA;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check("mid_rst_cnt",      0, 8'h14, 32'h0);
    check("mid_rst_valid",    2, 8'h00, 32'h0);
    check("mid_rst_in_stat",  0, 8'h04, 32'h0);
    check("mid_rst_in_data",  0, 8'h08, 32'h0);
    check("mid_rst_out_stat", 0, 8'h0C, 32'h1);
    check("mid_rst_out_data", 0, 8'h10, 32'h0);
    check("mid_rst_led",      1, 8'h00, 32'h0);

    // 4-bit counter wraps after 16 increments
    do_reset();
    check("cnt4_0",    4, 8'h00, 32'd0);
    idle(14);
    check("cnt4_15",   4, 8'h00, 32'd15);
    check("cnt4_wrap", 4, 8'h00, 32'd0);

    idle(2);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/io_responder.md
Name: io_responder

Overview:
- Peripheral-side endpoint of the CPU IO bus: decodes io_addr and io_we/io_rd and responds on io_din.
- Holds the memory-mapped registers for the board: LEDs, a buffered input port with a status flag, a handshaked output port to the display, and a free-running cycle counter.
- Sits between the CPU core and the board I/O logic. It is the only block that drives io_din.

Parameters:
- LED_W, 16, width of the LED output register.
- CNT_W, 32, cycle counter width (2..32); zero-extended on read.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- io_addr  input  8  register byte address from CPU
- io_dout  input  32  write data from CPU
- io_we  input  1  write strobe, one cycle per store
- io_rd  input  1  read strobe, one cycle per load
- io_din  output  32  read data to CPU
- led  output  LED_W  LED register
- in_valid  input  1  input front end presents in_data this cycle (single-cycle pulse)
- in_data  input  32  input word
- out_valid  output  1  output word pending to display
- out_data  output  32  output word
- out_ack  input  1  display accepts word (handshake completes when out_valid&&out_ack)

Behaviour:
- Reset (rst=1 at clk edge) clears every register: led=0, in_buf=0, in_full=0, in_ovr=0, out_valid=0, out_data=0, out_err=0, cnt=0. Reset wins over every simultaneous event, including mid-handshake; a pending out_valid is dropped.
- Address map (exact byte addresses; any other address, including unaligned, reads 0 and ignores writes):
  - 0x00 LED: R/W; write led<=io_dout[LED_W-1:0].
  - 0x04 IN_STAT: R; {30'b0, in_ovr, in_full}.
  - 0x08 IN_DATA: R; returns in_buf.
  - 0x0C OUT_STAT: R; {30'b0, out_err, ~out_valid}; bit0 = ready.
  - 0x10 OUT_DATA: R/W; read returns out_data.
  - 0x14 CNT: R/W; read returns zero-extended cnt; any write clears it.
- Read path: io_din is combinational from io_addr, valid in the same cycle; it does not depend on io_rd. Read side effects commit at the clk edge where io_rd=1.
- Input port:
  - in_valid && !in_full: in_buf<=in_data, in_full<=1.
  - in_valid && in_full: data dropped, in_buf unchanged, in_ovr<=1 (sticky).
  - io_rd@0x08: in_full<=0.
  - io_rd@0x08 && in_valid in the same cycle: the old word is consumed, the new word is latched, and in_full stays 1. No overrun.
  - io_rd@0x04: in_ovr<=0 after the read returns it. If a new overrun occurs in the same cycle, in_ovr stays 1.
- Output port:
  - io_we@0x10 && !out_valid: out_data<=io_dout, out_valid<=1 on the next cycle.
  - io_we@0x10 while out_valid=1: ignored, out_data unchanged, out_err<=1 (sticky).
  - out_valid&&out_ack: out_valid<=0. out_data is held (readable).
  - out_ack while out_valid=0: no effect.
  - Handshake completing in the same cycle as a write to 0x10: the write is treated as busy (out_err set, data ignored).
  - io_rd@0x0C: out_err<=0, unless set again in the same cycle.
  - out_data is stable for the whole time out_valid=1.
- Counter: cnt increments by 1 every cycle and wraps from all-ones to 0. A write to 0x14 takes priority over the increment, so cnt=0 on the next cycle.
- io_we and io_rd both asserted: both take effect.
- Latency: register writes are visible on io_din the cycle after the io_we edge. Handshake outputs are registered; no combinational path from out_ack or in_valid to outputs other than io_din.

Test Plan:
- Reset then reads: rst 1 cycle -> io_din@0x00=0, @0x04=0, @0x0C=1, led=0, out_valid=0. @0x14 reads 0 in the first cycle after reset, then 1, 2, …
- LED: io_we@0x00 io_dout=0xFFFF_A5A5 -> led=0xA5A5 next cycle, io_din@0x00=0x0000_A5A5. Write @0x03 -> led unchanged.
- Input buffer: in_valid with 0x1234 -> @0x04=1, @0x08=0x1234. Second in_valid 0x5678 before the read -> @0x04=3, @0x08 still 0x1234. io_rd@0x08 -> @0x04=2. io_rd@0x04 -> @0x04=0. Also read @0x08 concurrent with in_valid 0x9 -> @0x08=0x9, @0x04=1.
- Output handshake: io_we@0x10 0xDEAD -> out_valid=1, out_data=0xDEAD, @0x0C=0. Second write 0xBEEF while out_ack=0 -> out_data=0xDEAD, @0x0C=2. out_ack=1 -> out_valid=0, @0x0C=3. io_rd@0x0C -> then 1.
- Counter: run 10 cycles, io_we@0x14 -> next read 0. With CNT_W=4, after 16 increments the value wraps to 0.
- Reset mid-operation: out_valid=1, in_full=1, in_ovr=1, assert rst -> all cleared next cycle. A concurrent in_valid during reset is not latched.
